// File: rtl/distributor4.sv
// distributor4: steers one input word per transfer into one of eight one-entry
// output slots (4 lanes x bank A/B), chosen manually or by a round-robin pointer.
module distributor4 #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [1:0]                   in_lane,
  input  logic                         in_bank,
  input  logic                         auto_mode,
  input  logic                         flush,
  output logic [LANES-1:0][WIDTH-1:0]  out_data_a,
  output logic [LANES-1:0]             out_valid_a,
  input  logic [LANES-1:0]             out_ready_a,
  output logic [LANES-1:0][WIDTH-1:0]  out_data_b,
  output logic [LANES-1:0]             out_valid_b,
  input  logic [LANES-1:0]             out_ready_b,
  output logic [2:0]                   rr_ptr
);

  // Slot index is {bank, lane}: 0..3 are bank A lanes, 4..7 are bank B lanes.
  logic [2*LANES-1:0][WIDTH-1:0] data_q, data_d;
  logic [2*LANES-1:0]            valid_q, valid_d;
  logic [2:0]                    rr_ptr_q, rr_ptr_d;

  logic [2:0]                    tgt_s;
  logic [2*LANES-1:0]            slot_ready_s;
  logic                          in_ready_s;
  logic                          accept_s;

  // Target selection, handshake and next-state computation
  always_comb begin
    slot_ready_s = {out_ready_b, out_ready_a};
    if (auto_mode) begin
      tgt_s = rr_ptr_q;
    end else begin
      tgt_s = {in_bank, in_lane};
    end

    in_ready_s = ~flush & (~valid_q[tgt_s] | slot_ready_s[tgt_s]);
    accept_s   = in_valid & in_ready_s;

    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      // Consumed slots drain; an accept below may refill the same slot.
      valid_d = valid_q & ~slot_ready_s;
    end

    if (accept_s) begin
      valid_d[tgt_s] = 1'b1;
      data_d[tgt_s]  = in_data;
    end else begin
      valid_d[tgt_s] = valid_d[tgt_s];
    end

    if (accept_s && auto_mode) begin
      rr_ptr_d = rr_ptr_q + 3'd1;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      valid_q  <= '0;
      rr_ptr_q <= 3'd0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_data_a  = data_q[LANES-1:0];
  assign out_data_b  = data_q[2*LANES-1:LANES];
  assign out_valid_a = valid_q[LANES-1:0];
  assign out_valid_b = valid_q[2*LANES-1:LANES];
  assign rr_ptr      = rr_ptr_q;

endmodule
